// File: rtl/uart_tx_param_pkg.sv
// Shared types and helpers for the parametrised UART transmitter.
// Parity support is compiled in by defining UART_TX_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam int DEF_CLK_DIV   = 5208;
    localparam int MAX_DATA_BITS = 9;

    // Narrower words are zero-extended by the caller, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Valid/ready word handshake between the packet logic and the UART transmitter.
interface uart_tx_param_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input  tx_ready);
    modport slave  (input  tx_data, input  tx_valid, output tx_ready);
endinterface

// File: rtl/uart_tx_param_baud_gen.sv
// Bit-period timer: bit_tick is high on the last clk cycle of each bit period.
// Held cleared while en is low so every frame starts on a fresh period.
import uart_pkg::*;

module uart_baud_gen #(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic bit_tick
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || !en)
            cnt <= '0;
        else if (cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 1'b1;
    end

    assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: START, DATA_BITS data LSB first, optional parity, STOP_BITS stop.
// Define UART_TX_PARITY_EN to insert a parity bit (sense selected by PARITY_ODD).
import uart_pkg::*;

module uart_tx_param #(
    parameter int CLK_DIV    = DEF_CLK_DIV,
    parameter int DATA_BITS  = 8,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_param_if.slave     bus,
    output logic               tx,
    output logic               busy,
    output logic               done
);
    localparam int            BW        = $clog2(DATA_BITS + 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    generate
        if (CLK_DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            (STOP_BITS != 1 && STOP_BITS != 2) ||
            (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
            $error("uart_tx_param: illegal parameter combination");
        end
    endgenerate

    state_t                state;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_BITS-1:0]  shreg;
    logic                  bit_tick;
    logic                  baud_en;
`ifdef UART_TX_PARITY_EN
    localparam logic       ODD = (PARITY_ODD != 0);
    logic                  par_bit;
`endif

    assign baud_en      = (state != IDLE);
    assign bus.tx_ready = (state == IDLE);
    assign done         = (state == STOP) && bit_tick && (bit_cnt == LAST_STOP);

    uart_baud_gen #(.CLK_DIV(CLK_DIV)) u_baud (
        .clk      (clk),
        .rst      (rst),
        .en       (baud_en),
        .bit_tick (bit_tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            busy    <= 1'b0;
            bit_cnt <= '0;
            shreg   <= '0;
`ifdef UART_TX_PARITY_EN
            par_bit <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.tx_valid) begin
                        shreg   <= bus.tx_data;
`ifdef UART_TX_PARITY_EN
                        par_bit <= calc_parity(MAX_DATA_BITS'(bus.tx_data), ODD);
`endif
                        state   <= START;
                        tx      <= 1'b0;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        shreg   <= shreg >> 1;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= par_bit;
`else
                            state   <= STOP;
                            tx      <= 1'b1;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shreg[0];
                            shreg   <= shreg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state   <= STOP;
                        tx      <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
`endif
                STOP: begin
                    // The last stop tick is the done cycle; IDLE follows on the next edge.
                    if (bit_tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    busy    <= 1'b0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench: 8N1, 8-data/2-stop back-to-back, 7-data odd-parity instances at CLK_DIV=4.
// Expectations follow UART_TX_PARITY_EN when the bench is built with that macro.
module tb_uart_tx_param;
    localparam int CD = 4;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    uart_tx_param_if #(.DATA_BITS(8)) ifa ();
    uart_tx_param_if #(.DATA_BITS(8)) ifb ();
    uart_tx_param_if #(.DATA_BITS(7)) ifc ();
    logic tx_a, busy_a, done_a;
    logic tx_b, busy_b, done_b;
    logic tx_c, busy_c, done_c;

    uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_a (
        .clk(clk), .rst(rst), .bus(ifa), .tx(tx_a), .busy(busy_a), .done(done_a));
    uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(2), .PARITY_ODD(0)) u_b (
        .clk(clk), .rst(rst), .bus(ifb), .tx(tx_b), .busy(busy_b), .done(done_b));
    uart_tx_param #(.CLK_DIV(CD), .DATA_BITS(7), .STOP_BITS(1), .PARITY_ODD(1)) u_c (
        .clk(clk), .rst(rst), .bus(ifc), .tx(tx_c), .busy(busy_c), .done(done_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int w, input logic v, input logic [8:0] d);
        case (w)
            0: begin ifa.tx_valid = v; ifa.tx_data = d[7:0]; end
            1: begin ifb.tx_valid = v; ifb.tx_data = d[7:0]; end
            default: begin ifc.tx_valid = v; ifc.tx_data = d[6:0]; end
        endcase
    endtask

    task automatic set_valid(input int w, input logic v);
        case (w)
            0: ifa.tx_valid = v;
            1: ifb.tx_valid = v;
            default: ifc.tx_valid = v;
        endcase
    endtask

    // {ready, busy, done, tx}
    function automatic logic [3:0] probe(input int w);
        case (w)
            0: return {ifa.tx_ready, busy_a, done_a, tx_a};
            1: return {ifb.tx_ready, busy_b, done_b, tx_b};
            default: return {ifc.tx_ready, busy_c, done_c, tx_c};
        endcase
    endfunction

    function automatic logic exp_bit(input logic [8:0] word, input int nd, input logic odd, input int idx);
        logic par;
        par = odd;
        for (int i = 0; i < nd; i++) par ^= word[i];
        if (idx == 0) return 1'b0;
        if (idx <= nd) return word[idx-1];
        if (PB == 1 && idx == nd + 1) return par;
        return 1'b1;
    endfunction

    task automatic start(input int w, input logic [8:0] d);
        logic [3:0] p;
        int n;
        n = 0;
        @(negedge clk);
        drive(w, 1'b1, d);
        p = probe(w);
        while (!p[3] && n < 20) begin
            @(negedge clk);
            p = probe(w);
            n++;
        end
        chk("start_ready", p[3], 1);
    endtask

    // Checks every cycle of one frame (acceptance on the edge before cycle 1) plus the gap cycle.
    task automatic expect_frame(input int w, input logic [8:0] word, input int nd, input int ns,
                                input logic odd, input bit hold, input logic [8:0] nxt,
                                input bit pulse, input string tag);
        int L;
        logic [3:0] p;
        L = (1 + nd + PB + ns) * CD;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            if (k == 1 && !hold) set_valid(w, 1'b0);
            if (k == 2 && hold) drive(w, 1'b1, nxt);
            if (pulse && k == 10) set_valid(w, 1'b1);
            if (pulse && k == 11) set_valid(w, 1'b0);
            p = probe(w);
            chk({tag, "_tx"},    p[0], exp_bit(word, nd, odd, (k - 1) / CD));
            chk({tag, "_done"},  p[1], (k == L));
            chk({tag, "_busy"},  p[2], 1);
            chk({tag, "_ready"}, p[3], 0);
        end
        @(negedge clk);
        p = probe(w);
        chk({tag, "_gap_tx"},    p[0], 1);
        chk({tag, "_gap_done"},  p[1], 0);
        chk({tag, "_gap_busy"},  p[2], 0);
        chk({tag, "_gap_ready"}, p[3], 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] p;
        drive(0, 1'b0, 9'h0);
        drive(1, 1'b0, 9'h0);
        drive(2, 1'b0, 9'h0);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        p = probe(0);
        chk("rst_tx", p[0], 1);
        chk("rst_done", p[1], 0);
        chk("rst_busy", p[2], 0);
        chk("rst_ready", p[3], 1);
        rst = 1'b0;

        // 8N1 0x55 and zero data
        start(0, 9'h55);
        expect_frame(0, 9'h55, 8, 1, 1'b0, 1'b0, 9'h0, 1'b0, "f55");
        start(0, 9'h00);
        expect_frame(0, 9'h00, 8, 1, 1'b0, 1'b0, 9'h0, 1'b0, "zero");
        start(0, 9'h07);
        expect_frame(0, 9'h07, 8, 1, 1'b0, 1'b0, 9'h0, 1'b0, "even07");

        // 7-bit odd parity
        start(2, 9'h03);
        expect_frame(2, 9'h03, 7, 1, 1'b1, 1'b0, 9'h0, 1'b0, "odd03");
        start(2, 9'h07);
        expect_frame(2, 9'h07, 7, 1, 1'b1, 1'b0, 9'h0, 1'b0, "odd07");

        // back-to-back, 2 stop bits, data change after acceptance, mid-frame valid pulse
        start(1, 9'hA5);
        expect_frame(1, 9'hA5, 8, 2, 1'b0, 1'b1, 9'h3C, 1'b0, "b2b1");
        expect_frame(1, 9'h3C, 8, 2, 1'b0, 1'b0, 9'h0, 1'b1, "b2b2");
        repeat (8) begin
            @(negedge clk);
            p = probe(1);
            chk("b2b_idle_busy", p[2], 0);
            chk("b2b_idle_tx", p[0], 1);
        end

        // reset during data bit 3
        start(0, 9'h55);
        @(negedge clk);
        set_valid(0, 1'b0);
        repeat (17) @(negedge clk);
        p = probe(0);
        chk("pre_rst_busy", p[2], 1);
        rst = 1'b1;
        @(negedge clk);
        p = probe(0);
        chk("mid_rst_tx", p[0], 1);
        chk("mid_rst_done", p[1], 0);
        chk("mid_rst_busy", p[2], 0);
        chk("mid_rst_ready", p[3], 1);
        rst = 1'b0;
        repeat (8) begin
            @(negedge clk);
            p = probe(0);
            chk("post_rst_done", p[1], 0);
            chk("post_rst_tx", p[0], 1);
        end
        start(0, 9'hA5);
        expect_frame(0, 9'hA5, 8, 1, 1'b0, 1'b0, 9'h0, 1'b0, "after_rst");

        // valid held through reset: accepted on the first edge after release
        @(negedge clk);
        rst = 1'b1;
        drive(0, 1'b1, 9'h3C);
        repeat (3) begin
            @(negedge clk);
            p = probe(0);
            chk("hold_rst_busy", p[2], 0);
            chk("hold_rst_tx", p[0], 1);
            chk("hold_rst_ready", p[3], 1);
        end
        rst = 1'b0;
        expect_frame(0, 9'h3C, 8, 1, 1'b0, 1'b0, 9'h0, 1'b0, "hold");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
